// File: rtl/conv_encoder_1_2.sv
// Rate-1/2 feedforward convolutional encoder, constraint length K, octal generators.
// One information bit per valid cycle; registered {c0,c1} symbol one clock later.
module conv_encoder_1_2 #(
   parameter int unsigned K      = 3,
   parameter logic [8:0]  G0_OCT = 9'o007,
   parameter logic [8:0]  G1_OCT = 9'o005
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         seed_load,
   input  logic [K-2:0] seed_value,
   input  logic         in_valid,
   input  logic         in_bit,
   output logic         out_valid,
   output logic [1:0]   out_sym
);

   localparam int unsigned M = K - 1;
   localparam logic [K-1:0] G0 = G0_OCT[K-1:0];
   localparam logic [K-1:0] G1 = G1_OCT[K-1:0];

   logic [M-1:0] state_q, state_d;
   logic         valid_q, valid_d;
   logic [1:0]   sym_q,   sym_d;
   logic [K-1:0] r_w;
   logic         c0_w, c1_w;

   // Current input sits at the MSB; state[0] is the oldest bit.
   assign r_w  = {in_bit, state_q};
   assign c0_w = ^(r_w & G0);
   assign c1_w = ^(r_w & G1);

   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      sym_d   = sym_q;
      if (seed_load) begin
         state_d = seed_value;
      end else if (in_valid) begin
         sym_d   = {c0_w, c1_w};
         valid_d = 1'b1;
         state_d = r_w[K-1:1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         valid_q <= 1'b0;
         sym_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         sym_q   <= sym_d;
      end
   end

   assign out_valid = valid_q;
   assign out_sym   = sym_q;

endmodule

// File: tb/tb_conv_encoder_1_2.sv
// Scoreboarded bench for conv_encoder_1_2: a K=3 (7,5) and a K=4 (17,13) instance
// driven by the same stimulus, each checked against an independent bit-serial model.
module tb_conv_encoder_1_2;

   logic       clk = 1'b0;
   logic       rst, seed_load, in_valid, in_bit;
   logic [1:0] sv3;
   logic [2:0] sv4;
   logic       out_valid3, out_valid4;
   logic [1:0] out_sym3, out_sym4;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [2:0] q3[$];
   logic [2:0] q4[$];
   logic [2:0] e3, e4;

   // Reference model state
   logic [7:0] ms3, ms4;
   logic       mv3, mv4;
   logic [1:0] my3, my4;

   always #5 clk = ~clk;

   conv_encoder_1_2 #(.K(3), .G0_OCT(9'o007), .G1_OCT(9'o005)) dut3 (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed_value(sv3),
      .in_valid(in_valid), .in_bit(in_bit), .out_valid(out_valid3), .out_sym(out_sym3));

   conv_encoder_1_2 #(.K(4), .G0_OCT(9'o017), .G1_OCT(9'o013)) dut4 (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed_value(sv4),
      .in_valid(in_valid), .in_bit(in_bit), .out_valid(out_valid4), .out_sym(out_sym4));

   // Parity over taps: mask bit k-1 pairs with the new bit, mask bit i<k-1 with state[i].
   function automatic logic par(input int k, input logic [7:0] mask, input logic b,
                                input logic [7:0] st);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < k - 1; i++)
         if (mask[i] && st[i]) acc = ~acc;
      if (mask[k-1] && b) acc = ~acc;
      return acc;
   endfunction

   // Applies one cycle of stimulus, advances both models, queues the expected outputs.
   task automatic drive(input logic r, input logic sl, input logic [2:0] sv,
                        input logic iv, input logic b);
      rst = r; seed_load = sl; in_valid = iv; in_bit = b;
      sv3 = sv[1:0]; sv4 = sv;
      if (r) begin
         ms3 = '0; mv3 = 1'b0; my3 = 2'b00;
         ms4 = '0; mv4 = 1'b0; my4 = 2'b00;
      end else if (sl) begin
         ms3 = {6'b0, sv[1:0]}; mv3 = 1'b0;
         ms4 = {5'b0, sv};      mv4 = 1'b0;
      end else if (iv) begin
         my3 = {par(3, 8'o07, b, ms3), par(3, 8'o05, b, ms3)};
         my4 = {par(4, 8'o17, b, ms4), par(4, 8'o13, b, ms4)};
         mv3 = 1'b1; mv4 = 1'b1;
         ms3 = (ms3 >> 1) | ({7'b0, b} << 1);
         ms4 = (ms4 >> 1) | ({7'b0, b} << 2);
      end else begin
         mv3 = 1'b0; mv4 = 1'b0;
      end
      q3.push_back({mv3, my3});
      q4.push_back({mv4, my4});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 3'b000, 0, 0);
      drive(1, 1, 3'b111, 1, 1);
      for (int i = 0; i < 2; i++) begin
         e3 = q3.pop_front(); e4 = q4.pop_front();
      end
      checks++;
      if ({out_valid3, out_sym3} !== 3'b000) begin
         errors++; $display("FAIL reset_k3 got %b exp 000", {out_valid3, out_sym3});
      end
      checks++;
      if ({out_valid4, out_sym4} !== 3'b000) begin
         errors++; $display("FAIL reset_k4 got %b exp 000", {out_valid4, out_sym4});
      end
      drive(0, 0, 3'b000, 0, 0);
      e3 = q3.pop_front(); e4 = q4.pop_front();
   endtask

   task automatic test_basic();
      logic [1:0] lit [2] = '{2'b00, 2'b11};
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 3'b000, 1, i[0]);
         e3 = q3.pop_front(); e4 = q4.pop_front();
         checks++;
         if ({out_valid3, out_sym3} !== {1'b1, lit[i]}) begin
            errors++; $display("FAIL basic_k3 idx %0d got %b exp %b", i, {out_valid3, out_sym3}, {1'b1, lit[i]});
         end
         checks++;
         if ({out_valid4, out_sym4} !== e4) begin
            errors++; $display("FAIL basic_k4 idx %0d got %b exp %b", i, {out_valid4, out_sym4}, e4);
         end
      end
      checks++;
      if (dut3.state_q !== 2'b10) begin
         errors++; $display("FAIL basic_state got %b exp 10", dut3.state_q);
      end
   endtask

   task automatic test_zeros_ones();
      logic [1:0] lit;
      drive(1, 0, 3'b000, 0, 0);
      e3 = q3.pop_front(); e4 = q4.pop_front();
      for (int i = 0; i < 33; i++) begin
         // 16 zeros, one idle cycle, then 16 ones
         if (i == 16) drive(0, 0, 3'b000, 0, 0);
         else         drive(0, 0, 3'b000, 1, i > 16);
         e3 = q3.pop_front(); e4 = q4.pop_front();
         if (i < 16)       lit = 2'b00;
         else if (i == 16) lit = 2'b00;
         else if (i == 17) lit = 2'b11;
         else if (i == 18) lit = 2'b01;
         else              lit = 2'b10;
         checks++;
         if ({out_valid3, out_sym3} !== {i != 16, lit} || e3 !== {i != 16, lit}) begin
            errors++; $display("FAIL zeros_ones_k3 idx %0d got %b exp %b", i, {out_valid3, out_sym3}, {i != 16, lit});
         end
         checks++;
         if ({out_valid4, out_sym4} !== e4) begin
            errors++; $display("FAIL zeros_ones_k4 idx %0d got %b exp %b", i, {out_valid4, out_sym4}, e4);
         end
      end
   endtask

   task automatic test_alternating();
      logic [1:0] lit [6] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00};
      drive(1, 0, 3'b000, 0, 0);
      e3 = q3.pop_front(); e4 = q4.pop_front();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 3'b000, 1, i[0]);
         e3 = q3.pop_front(); e4 = q4.pop_front();
         checks++;
         if ({out_valid3, out_sym3} !== {1'b1, lit[i]}) begin
            errors++; $display("FAIL alt_k3 idx %0d got %b exp %b", i, {out_valid3, out_sym3}, {1'b1, lit[i]});
         end
         checks++;
         if ({out_valid4, out_sym4} !== e4) begin
            errors++; $display("FAIL alt_k4 idx %0d got %b exp %b", i, {out_valid4, out_sym4}, e4);
         end
      end
   endtask

   task automatic test_seed();
      // Load with in_valid also high: load wins, bit ignored, no output pulse.
      drive(0, 1, 3'b010, 1, 1);
      e3 = q3.pop_front(); e4 = q4.pop_front();
      checks++;
      if (out_valid3 !== 1'b0 || out_valid4 !== 1'b0 || out_sym3 !== e3[1:0]) begin
         errors++; $display("FAIL seed_load got v3=%b v4=%b s3=%b exp v=0 s3=%b", out_valid3, out_valid4, out_sym3, e3[1:0]);
      end
      drive(0, 0, 3'b000, 1, 0);
      e3 = q3.pop_front(); e4 = q4.pop_front();
      // K=3: r=010 -> c0=1 (111), c1=0 (101)
      checks++;
      if ({out_valid3, out_sym3} !== 3'b110) begin
         errors++; $display("FAIL seed_sym_k3 got %b exp 110", {out_valid3, out_sym3});
      end
      checks++;
      if ({out_valid4, out_sym4} !== e4) begin
         errors++; $display("FAIL seed_sym_k4 got %b exp %b", {out_valid4, out_sym4}, e4);
      end
   endtask

   task automatic test_random(input int n, input int idle_pct, input string nm);
      for (int i = 0; i < n; i++) begin
         if (($urandom % 64) == 0)
            drive(0, 1, 3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
         else
            drive(0, 0, 3'b000, $urandom_range(0, 99) >= idle_pct, $urandom_range(0, 1));
         e3 = q3.pop_front(); e4 = q4.pop_front();
         checks++;
         if ({out_valid3, out_sym3} !== e3) begin
            errors++; $display("FAIL %s_k3 idx %0d got %b exp %b", nm, i, {out_valid3, out_sym3}, e3);
         end
         checks++;
         if ({out_valid4, out_sym4} !== e4) begin
            errors++; $display("FAIL %s_k4 idx %0d got %b exp %b", nm, i, {out_valid4, out_sym4}, e4);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 3'b000, 1, 1);
         e3 = q3.pop_front(); e4 = q4.pop_front();
      end
      drive(1, 0, 3'b000, 1, 1);
      e3 = q3.pop_front(); e4 = q4.pop_front();
      checks++;
      if (out_valid3 !== 1'b0 || out_valid4 !== 1'b0) begin
         errors++; $display("FAIL mid_reset_valid got %b%b exp 00", out_valid3, out_valid4);
      end
      drive(0, 0, 3'b000, 1, 1);
      e3 = q3.pop_front(); e4 = q4.pop_front();
      checks++;
      if ({out_valid3, out_sym3} !== 3'b111) begin
         errors++; $display("FAIL mid_reset_k3 got %b exp 111", {out_valid3, out_sym3});
      end
      checks++;
      if ({out_valid4, out_sym4} !== 3'b111 || e4 !== 3'b111) begin
         errors++; $display("FAIL mid_reset_k4 got %b exp 111", {out_valid4, out_sym4});
      end
   endtask

   initial begin
      rst = 1'b1; seed_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      sv3 = '0; sv4 = '0;
      ms3 = '0; ms4 = '0; mv3 = 1'b0; mv4 = 1'b0; my3 = '0; my4 = '0;
      test_reset();
      test_basic();
      test_zeros_ones();
      test_alternating();
      test_random(200, 25, "rand25");
      test_seed();
      test_random(1000, 10, "rand10");
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
